// File: rtl/nvdla_mcif_eg_pkg.sv
// ---------------------------------------------------------------------------
// nvdla_mcif_eg_pkg
// Shared definitions for the MCIF write-egress block:
//   - AXI BRESP encodings
//   - response-FIFO entry layout {idx, bresp, bad}
//   - completion-queue entry field offsets ({len, require_ack}, ack in bit 0)
//   - clog2 helper usable in parameter expressions
// ---------------------------------------------------------------------------
package nvdla_mcif_eg_pkg;

    typedef enum logic [1:0] {
        BrespOkay   = 2'b00,
        BrespExokay = 2'b01,
        BrespSlverr = 2'b10,
        BrespDecerr = 2'b11
    } bresp_e;

    // Widest client index supported (16 clients); narrower configs zero-extend.
    localparam int unsigned IDX_MAX_W = 4;

    typedef struct packed {
        logic [IDX_MAX_W-1:0] idx;
        bresp_e               bresp;
        logic                 bad;
    } rsp_entry_t;

    localparam int unsigned RSP_ENTRY_W = $bits(rsp_entry_t);

    // Completion-queue entry layout: {len[LEN_W-1:0], require_ack}
    localparam int unsigned CQ_ACK_OFF = 0;
    localparam int unsigned CQ_LEN_OFF = 1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/nvdla_mcif_eg_rsp_fifo.sv
// ---------------------------------------------------------------------------
// nvdla_mcif_eg_rsp_fifo
// Generic flop-based FIFO with registered occupancy.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_wdata: write request (ignored when full)
//   i_pop          : read request (ignored when empty)
//   o_rdata        : head entry (valid when !o_empty)
//   o_full, o_empty: derived from the registered occupancy counter only
// DEPTH must be a power of two >= 2 so pointers wrap naturally.
// ---------------------------------------------------------------------------
module nvdla_mcif_eg_rsp_fifo
    import nvdla_mcif_eg_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_cnt;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_rdata = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/nvdla_mcif_write_eg_mc.sv
// ---------------------------------------------------------------------------
// nvdla_mcif_write_eg_mc
// MCIF write egress: buffers AXI B responses and retires them, in order,
// against per-client completion queues.
//   nvdla_core_clk / nvdla_core_rstn  : clock, async active-low reset
//   noc2mcif_axi_b_*                  : AXI B channel from the NoC
//   cq_rd_pvld / cq_rd_prdy / cq_rd_pd: per-client completion-queue pop
//   eg2ig_axi_vld / eg2ig_axi_len     : registered burst-length return
//   mcif2client_wr_rsp_complete       : registered per-client completion
//   wr_rsp_err / bad_id_err / err_cnt : sticky error status, cleared by err_clr
// ---------------------------------------------------------------------------
module nvdla_mcif_write_eg_mc
    import nvdla_mcif_eg_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = 5,
    parameter int unsigned ID_W        = 8,
    parameter int unsigned LEN_W       = 2,
    parameter int unsigned RSP_DEPTH   = 2,
    parameter int unsigned ERR_CNT_W   = 8
) (
    input  logic                            nvdla_core_clk,
    input  logic                            nvdla_core_rstn,
    input  logic                            noc2mcif_axi_b_bvalid,
    output logic                            noc2mcif_axi_b_bready,
    input  logic [ID_W-1:0]                 noc2mcif_axi_b_bid,
    input  logic [1:0]                      noc2mcif_axi_b_bresp,
    input  logic [NUM_CLIENTS-1:0]          cq_rd_pvld,
    output logic [NUM_CLIENTS-1:0]          cq_rd_prdy,
    input  logic [NUM_CLIENTS*(LEN_W+1)-1:0] cq_rd_pd,
    output logic                            eg2ig_axi_vld,
    output logic [LEN_W-1:0]                eg2ig_axi_len,
    output logic [NUM_CLIENTS-1:0]          mcif2client_wr_rsp_complete,
    output logic [NUM_CLIENTS-1:0]          wr_rsp_err,
    output logic                            bad_id_err,
    output logic [ERR_CNT_W-1:0]            err_cnt,
    input  logic                            err_clr
);

    localparam int unsigned IDX_W = (NUM_CLIENTS > 1) ? clog2(NUM_CLIENTS) : 1;
    localparam int unsigned PD_W  = LEN_W + 1;

    // ---------------- response FIFO ----------------
    rsp_entry_t             w_wr_entry;
    rsp_entry_t             w_head;
    logic [RSP_ENTRY_W-1:0] w_fifo_wdata;
    logic [RSP_ENTRY_W-1:0] w_fifo_rdata;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic                   w_fifo_pop;
    logic                   w_push;
    logic [IDX_W-1:0]       w_bid_idx;
    logic                   r_bready_en;

    assign w_bid_idx        = noc2mcif_axi_b_bid[IDX_W-1:0];
    assign w_wr_entry.idx   = IDX_MAX_W'(w_bid_idx);
    assign w_wr_entry.bresp = bresp_e'(noc2mcif_axi_b_bresp);
    // Full-width compare also catches nonzero bits above the index field.
    assign w_wr_entry.bad   = (64'(noc2mcif_axi_b_bid) >= 64'(NUM_CLIENTS));
    assign w_fifo_wdata     = w_wr_entry;
    assign w_head           = rsp_entry_t'(w_fifo_rdata);

    // Ready depends only on registered state; held low until out of reset.
    assign noc2mcif_axi_b_bready = r_bready_en & ~w_fifo_full;
    assign w_push                = noc2mcif_axi_b_bvalid & noc2mcif_axi_b_bready;

    nvdla_mcif_eg_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (RSP_ENTRY_W)
    ) u_rsp_fifo (
        .i_clk   (nvdla_core_clk),
        .i_rst_n (nvdla_core_rstn),
        .i_push  (w_push),
        .i_wdata (w_fifo_wdata),
        .i_pop   (w_fifo_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // ---------------- head decode ----------------
    logic [NUM_CLIENTS-1:0] w_sel;
    logic [PD_W-1:0]        w_pd_sel;
    logic                   w_head_good;
    logic                   w_bad_pop;
    logic                   w_good_pop;
    logic [NUM_CLIENTS-1:0] w_cq_pop;
    logic [LEN_W-1:0]       w_len;
    logic                   w_ack;
    logic                   w_is_err_rsp;
    logic                   w_err_inc;
    logic [NUM_CLIENTS-1:0] w_err_set;

    always_comb begin
        w_sel    = '0;
        w_pd_sel = '0;
        for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
            if (w_head.idx == IDX_MAX_W'(k)) begin
                w_sel[k] = 1'b1;
                w_pd_sel = cq_rd_pd[k*PD_W +: PD_W];
            end
        end
    end

    assign w_head_good  = ~w_fifo_empty & ~w_head.bad;
    assign w_bad_pop    = ~w_fifo_empty & w_head.bad;
    assign cq_rd_prdy   = w_head_good ? w_sel : '0;
    assign w_cq_pop     = cq_rd_prdy & cq_rd_pvld;
    assign w_good_pop   = |w_cq_pop;
    assign w_fifo_pop   = w_good_pop | w_bad_pop;

    assign w_len        = w_pd_sel[CQ_LEN_OFF +: LEN_W];
    assign w_ack        = w_pd_sel[CQ_ACK_OFF];

    assign w_is_err_rsp = (w_head.bresp == BrespSlverr) || (w_head.bresp == BrespDecerr);
    assign w_err_set    = w_cq_pop & {NUM_CLIENTS{w_is_err_rsp}};
    assign w_err_inc    = (w_good_pop & w_is_err_rsp) | w_bad_pop;

    // ---------------- error next-state ----------------
    logic [ERR_CNT_W-1:0]   w_err_cnt_nxt;
    logic [NUM_CLIENTS-1:0] w_wr_rsp_err_nxt;
    logic                   w_bad_id_err_nxt;

    // A clear coinciding with a new error still records that error.
    always_comb begin
        w_err_cnt_nxt    = err_cnt;
        w_wr_rsp_err_nxt = wr_rsp_err | w_err_set;
        w_bad_id_err_nxt = bad_id_err | w_bad_pop;
        if (err_clr) begin
            w_err_cnt_nxt    = w_err_inc ? ERR_CNT_W'(1) : '0;
            w_wr_rsp_err_nxt = w_err_set;
            w_bad_id_err_nxt = w_bad_pop;
        end else if (w_err_inc && (err_cnt != '1)) begin
            w_err_cnt_nxt = err_cnt + 1'b1;
        end
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_bready_en                 <= 1'b0;
            eg2ig_axi_vld               <= 1'b0;
            eg2ig_axi_len               <= '0;
            mcif2client_wr_rsp_complete <= '0;
            wr_rsp_err                  <= '0;
            bad_id_err                  <= 1'b0;
            err_cnt                     <= '0;
        end else begin
            r_bready_en                 <= 1'b1;
            eg2ig_axi_vld               <= w_good_pop;
            eg2ig_axi_len               <= w_good_pop ? w_len : '0;
            mcif2client_wr_rsp_complete <= w_ack ? w_cq_pop : '0;
            wr_rsp_err                  <= w_wr_rsp_err_nxt;
            bad_id_err                  <= w_bad_id_err_nxt;
            err_cnt                     <= w_err_cnt_nxt;
        end
    end

endmodule

// File: doc/nvdla_mcif_write_eg_mc.md
Name: nvdla_mcif_write_eg_mc

Overview:
Parametrised write-egress block for the MCIF write path. It accepts AXI B responses from the NoC into a small response FIFO and routes each response to the matching client's completion queue. Each routed response pops one queue entry, returns the burst length to write-ingress (eg2ig), and pulses a per-client write-complete when the entry requested an ack. It replaces the fixed 5-client single-flop egress, adding client-count/width parameters, response buffering, BRESP error tracking and bad-ID handling.

Parameters:
NUM_CLIENTS, 5, number of write clients and completion queues (1..16).
ID_W, 8, width of noc2mcif_axi_b_bid.
LEN_W, 2, burst-length field width in a completion-queue entry.
RSP_DEPTH, 2, response FIFO entries (power of 2, >=2).
ERR_CNT_W, 8, width of the saturating error counter.
Derived: IDX_W = max(1, clog2(NUM_CLIENTS)); PD_W = LEN_W+1.

Ports:
nvdla_core_clk  in  1  core clock
nvdla_core_rstn  in  1  asynchronous active-low reset
noc2mcif_axi_b_bvalid  in  1  B response valid
noc2mcif_axi_b_bready  out  1  B response ready
noc2mcif_axi_b_bid  in  ID_W  B response ID; low IDX_W bits select the client
noc2mcif_axi_b_bresp  in  2  B response code
cq_rd_pvld  in  NUM_CLIENTS  per-client completion-queue entry valid
cq_rd_prdy  out  NUM_CLIENTS  per-client completion-queue pop
cq_rd_pd  in  NUM_CLIENTS*PD_W  per-client entry, packed {len[LEN_W-1:0], require_ack}, client 0 in the LSBs
eg2ig_axi_vld  out  1  length-return pulse to ingress
eg2ig_axi_len  out  LEN_W  returned burst length
mcif2client_wr_rsp_complete  out  NUM_CLIENTS  per-client completion pulse
wr_rsp_err  out  NUM_CLIENTS  sticky flag: client received SLVERR/DECERR
bad_id_err  out  1  sticky flag: response ID >= NUM_CLIENTS or upper bits nonzero
err_cnt  out  ERR_CNT_W  saturating count of error responses
err_clr  in  1  clears wr_rsp_err, bad_id_err and err_cnt

Behaviour:
- Reset: FIFO empty; bready=0 while rstn low, 1 after; all other outputs 0; completions in flight are dropped; no cq entry is popped.
- bready = !fifo_full, taken from registered occupancy only. No combinational path from bvalid or cq_rd_pvld. A pop in the same cycle does not make a full FIFO ready.
- Push on bvalid&bready. The stored entry is {idx, bresp, bad}. bad=1 if bid >= NUM_CLIENTS.
- Head processing (head_vld = FIFO non-empty):
  - Bad head: pop in the same cycle. All cq_rd_prdy stay 0, no eg2ig or completion pulse, bad_id_err is set.
  - Good head with index k: cq_rd_prdy[k] = 1, all others 0 (one-hot or zero).
  - If cq_rd_pvld[k]: pop both the FIFO head and cq entry k that cycle.
  - Otherwise: the head stalls and prdy[k] stays asserted. Other clients are never served out of order.
- On a good pop with cq entry {len, ack}, in the next cycle:
  - eg2ig_axi_vld=1 and eg2ig_axi_len=len for exactly one cycle.
  - mcif2client_wr_rsp_complete[k]=ack for exactly one cycle.
  - Outputs are registered and return to 0 when there is no pop.
- Latency: B accepted at cycle t into an empty FIFO -> prdy[k] at t+1 -> pulses at t+2 if pvld. Sustained throughput is 1 response per cycle.
- Error: a good pop with bresp[1]=1 sets wr_rsp_err[k] and increments err_cnt, saturating at all-ones. A bad pop also increments err_cnt.
- err_clr in the same cycle as a new error: the result is flag set and err_cnt=1 (set wins).
- FIFO pointers wrap modulo RSP_DEPTH. Occupancy is held in a counter of width clog2(RSP_DEPTH)+1.
- Simultaneous push and pop when not full: occupancy is unchanged and both operations happen.

Decomposition:
- Package nvdla_mcif_eg_pkg holds:
  - BRESP encodings (OKAY/EXOKAY/SLVERR/DECERR);
  - the rsp-entry struct {idx, bresp, bad};
  - the cq-entry field offsets;
  - the clog2 helper.
- Sub-module nvdla_mcif_eg_rsp_fifo: a generic RSP_DEPTH-entry flop FIFO with full/empty, instantiated once.

Test Plan:
- Reset then single response: bid=2, bresp=0, cq2 entry {len=3, ack=1} already valid -> prdy[2] one cycle after accept, then eg2ig_vld=1 with len=3 and complete[2]=1 one cycle later. No other pulse.
- Head stall: bid=1 with cq1 empty for 5 cycles, then bid=0 pushed -> prdy[1] held high, prdy[0]=0, bready=0 once 2 entries are queued. cq1 valid -> pops in order 1 then 0.
- Back-to-back: 8 responses to clients 0..4 with all cq valid -> eg2ig_vld high 8 consecutive cycles, lengths match in order. bready never deasserts with RSP_DEPTH=2.
- ack=0 entry: eg2ig pulse occurs, complete stays 0.
- Errors: bresp=2 on client 4 -> wr_rsp_err[4]=1, err_cnt=1. bid=7 -> bad_id_err=1, err_cnt=2, no prdy. err_clr together with a new SLVERR -> err_cnt=1.
- Reset mid-operation: assert rstn low with 2 queued responses -> bready=0, all pulses 0, FIFO empty after release. Repeat with NUM_CLIENTS=16, ID_W=4, LEN_W=3.
